// File: rtl/rotor2_fwd_if.sv
// Interface: rotor2_fwd_if
// Bundles the per-letter handshake, the load port and the result bus of the
// rotor 2 forward stage. The master drives letters and loads and observes
// results; the slave is the rotor stage itself.
interface rotor2_fwd_if;
  logic       load;
  logic [4:0] load_pos;
  logic       in_valid;
  logic [4:0] in_letter;
  logic       step_in;
  logic       out_valid;
  logic [4:0] out_letter;
  logic [4:0] out_rotate;
  logic       step_out;
  logic       err;
  logic [4:0] pos;

  modport master (
    output load, load_pos, in_valid, in_letter, step_in,
    input  out_valid, out_letter, out_rotate, step_out, err, pos
  );

  modport slave (
    input  load, load_pos, in_valid, in_letter, step_in,
    output out_valid, out_letter, out_rotate, step_out, err, pos
  );
endinterface

// File: rtl/rotor2_fwd.sv
// Module: rotor2_fwd
// Forward path through Enigma rotor 2 (middle rotor). Holds the rotor position,
// steps it ahead of encipherment, and substitutes each letter through the
// rotor wiring offset by that position over a two-stage pipeline.
// Optional feature: define ROTOR2_DOUBLE_STEP_EN to enable the historical
// middle-rotor double-step; otherwise the rotor behaves as a pure odometer.
module rotor2_fwd #(
  parameter logic [4:0] NOTCH = 5'd4
) (
  input  logic          clk,
  input  logic          rst_n,
  rotor2_fwd_if.slave   bus
);

`ifdef ROTOR2_DOUBLE_STEP_EN
  localparam logic DS = 1'b1;
`else
  localparam logic DS = 1'b0;
`endif

  // Rotor 2 wiring, letters 1..26 (A=1) to letters 1..26.
  function automatic logic [4:0] wiring(input logic [4:0] l);
    case (l)
      5'd1:  wiring = 5'd6;
      5'd2:  wiring = 5'd15;
      5'd3:  wiring = 5'd11;
      5'd4:  wiring = 5'd21;
      5'd5:  wiring = 5'd4;
      5'd6:  wiring = 5'd1;
      5'd7:  wiring = 5'd26;
      5'd8:  wiring = 5'd14;
      5'd9:  wiring = 5'd17;
      5'd10: wiring = 5'd16;
      5'd11: wiring = 5'd24;
      5'd12: wiring = 5'd23;
      5'd13: wiring = 5'd2;
      5'd14: wiring = 5'd10;
      5'd15: wiring = 5'd9;
      5'd16: wiring = 5'd5;
      5'd17: wiring = 5'd8;
      5'd18: wiring = 5'd3;
      5'd19: wiring = 5'd13;
      5'd20: wiring = 5'd19;
      5'd21: wiring = 5'd7;
      5'd22: wiring = 5'd12;
      5'd23: wiring = 5'd18;
      5'd24: wiring = 5'd25;
      5'd25: wiring = 5'd20;
      5'd26: wiring = 5'd22;
      default: wiring = 5'd0;
    endcase
  endfunction

  // Position register
  logic [4:0] pos_q, pos_d;

  // Stage 1 registers
  logic       s1_valid_q, s1_valid_d;
  logic [4:0] s1_t_q,     s1_t_d;
  logic [4:0] s1_p_q,     s1_p_d;
  logic       s1_carry_q, s1_carry_d;
  logic       s1_err_q,   s1_err_d;

  // Stage 2 (output) registers
  logic       out_valid_q,  out_valid_d;
  logic [4:0] out_letter_q, out_letter_d;
  logic [4:0] out_rotate_q, out_rotate_d;
  logic       step_out_q,   step_out_d;
  logic       err_q,        err_d;

  // Helpers
  logic       letter_ok;
  logic       at_notch;
  logic       adv;
  logic [4:0] pos_inc;
  logic       load_err;
  logic [5:0] sum;
  logic [5:0] sum_wrap;

  // Position update and stage 1 capture: load wins, then valid letters step the rotor.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves a value unassigned and a latch can never be inferred.
    pos_d      = pos_q;
    s1_valid_d = 1'b0;
    s1_t_d     = 5'd0;
    s1_p_d     = 5'd0;
    s1_carry_d = 1'b0;
    s1_err_d   = 1'b0;
    load_err   = 1'b0;

    letter_ok = (bus.in_letter != 5'd0) && (bus.in_letter <= 5'd26);
    at_notch  = (pos_q == NOTCH);
    adv       = bus.step_in | (DS & at_notch);
    pos_inc   = (pos_q == 5'd25) ? 5'd0 : pos_q + 5'd1;

    if (bus.load) begin
      if (bus.load_pos <= 5'd25) begin
        pos_d = bus.load_pos;
      end else begin
        pos_d    = 5'd0;
        load_err = 1'b1;
      end
    end else if (bus.in_valid) begin
      s1_valid_d = 1'b1;
      if (letter_ok) begin
        // Stepping precedes encipherment: the letter sees the new position.
        pos_d      = adv ? pos_inc : pos_q;
        s1_t_d     = wiring(bus.in_letter);
        s1_p_d     = pos_d;
        s1_carry_d = adv & at_notch;
      end else begin
        s1_p_d   = pos_q;
        s1_err_d = 1'b1;
      end
    end
  end

  // Stage 2 next-state: offset addition modulo 26 into 1..26, error squashing.
  always_comb begin
    sum          = {1'b0, s1_t_q} + {1'b0, s1_p_q};
    sum_wrap     = (sum > 6'd26) ? sum - 6'd26 : sum;
    out_valid_d  = s1_valid_q;
    step_out_d   = s1_valid_q & s1_carry_q & ~s1_err_q;
    err_d        = (s1_valid_q & s1_err_q) | load_err;
    out_letter_d = out_letter_q;
    out_rotate_d = out_rotate_q;
    if (s1_valid_q) begin
      out_rotate_d = s1_p_q;
      out_letter_d = s1_err_q ? 5'd0 : sum_wrap[4:0];
    end
  end

  // Position register and stage 1 pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q      <= 5'd0;
      s1_valid_q <= 1'b0;
      s1_t_q     <= 5'd0;
      s1_p_q     <= 5'd0;
      s1_carry_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // present before the edge, independent of statement order.
      pos_q      <= pos_d;
      s1_valid_q <= s1_valid_d;
      s1_t_q     <= s1_t_d;
      s1_p_q     <= s1_p_d;
      s1_carry_q <= s1_carry_d;
      s1_err_q   <= s1_err_d;
    end
  end

  // Stage 2 output registers; letter and rotate hold between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_letter_q <= 5'd0;
      out_rotate_q <= 5'd0;
      step_out_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_letter_q <= out_letter_d;
      out_rotate_q <= out_rotate_d;
      step_out_q   <= step_out_d;
      err_q        <= err_d;
    end
  end

  assign bus.pos        = pos_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_letter = out_letter_q;
  assign bus.out_rotate = out_rotate_q;
  assign bus.step_out   = step_out_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_rotor2_fwd.sv
// Testbench: tb_rotor2_fwd
// Randomized and directed stimulus for rotor2_fwd, checked every cycle against
// a behavioural model that predicts outputs per clock edge from the rotor rules.
// Honours ROTOR2_DOUBLE_STEP_EN the same way the design does.
module tb_rotor2_fwd;

`ifdef ROTOR2_DOUBLE_STEP_EN
  localparam bit DS = 1'b1;
  localparam int NOTCH_POS_EXP    = 5;
  localparam int NOTCH_LETTER_EXP = 11;
  localparam int NOTCH_STEP_EXP   = 1;
`else
  localparam bit DS = 1'b0;
  localparam int NOTCH_POS_EXP    = 4;
  localparam int NOTCH_LETTER_EXP = 10;
  localparam int NOTCH_STEP_EXP   = 0;
`endif
  localparam int NOTCH = 4;
  localparam int DEPTH = 2048;

  logic clk;
  logic rst_n;
  rotor2_fwd_if bus_if ();

  rotor2_fwd #(.NOTCH(5'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int wiring [27] = '{0, 6, 15, 11, 21, 4, 1, 26, 14, 17, 16, 24, 23, 2, 10,
                      9, 5, 8, 3, 13, 19, 7, 12, 18, 25, 20, 22};

  // Expected outputs indexed by the clock edge after which they are visible.
  bit exp_valid  [DEPTH];
  int exp_letter [DEPTH];
  int exp_rotate [DEPTH];
  bit exp_step   [DEPTH];
  bit exp_err    [DEPTH];
  int exp_pos    [DEPTH];

  int edge_cnt = 0;
  int mpos = 0;
  int hold_letter = 0;
  int hold_rotate = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
    end
  endtask

  // Model: apply one cycle of inputs, to be sampled at edge e.
  task automatic model_apply(input int e, input bit ld, input int lp,
                             input bit iv, input int il, input bit si);
    bit adv, at_notch;
    int s;
    if (!rst_n) begin
      mpos = 0;
    end else if (ld) begin
      if (lp <= 25) mpos = lp;
      else begin
        mpos = 0;
        exp_err[e] = 1'b1;
      end
    end else if (iv) begin
      exp_valid[e+1] = 1'b1;
      if (il == 0 || il > 26) begin
        exp_letter[e+1] = 0;
        exp_rotate[e+1] = mpos;
        exp_step[e+1]   = 1'b0;
        exp_err[e+1]    = 1'b1;
      end else begin
        at_notch = (mpos == NOTCH);
        adv      = si || (DS && at_notch);
        if (adv) mpos = (mpos + 1) % 26;
        s = wiring[il] + mpos;
        exp_letter[e+1] = (s - 1) % 26 + 1;
        exp_rotate[e+1] = mpos;
        exp_step[e+1]   = adv && at_notch;
      end
    end
    exp_pos[e] = mpos;
  endtask

  // Drive one cycle of inputs (called just after a falling edge), return at next falling edge.
  task automatic cycle(input bit ld, input int lp, input bit iv, input int il, input bit si);
    bus_if.load      = ld;
    bus_if.load_pos  = lp[4:0];
    bus_if.in_valid  = iv;
    bus_if.in_letter = il[4:0];
    bus_if.step_in   = si;
    model_apply(edge_cnt + 1, ld, lp, iv, il, si);
    @(negedge clk);
  endtask

  task automatic idle();
    cycle(1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  // Compare process: every cycle, all outputs against the model.
  initial begin
    int k;
    forever begin
      @(negedge clk);
      k = edge_cnt;
      if (exp_valid[k]) begin
        hold_letter = exp_letter[k];
        hold_rotate = exp_rotate[k];
      end
      check("out_valid",  bus_if.out_valid,  exp_valid[k]);
      check("out_letter", bus_if.out_letter, hold_letter);
      check("out_rotate", bus_if.out_rotate, hold_rotate);
      check("step_out",   bus_if.step_out,   exp_step[k]);
      check("err",        bus_if.err,        exp_err[k]);
      check("pos",        bus_if.pos,        exp_pos[k]);
    end
  end

  initial begin
    rst_n = 1'b0;
    bus_if.load = 1'b0; bus_if.load_pos = '0; bus_if.in_valid = 1'b0;
    bus_if.in_letter = '0; bus_if.step_in = 1'b0;
    check("reset_pos",   bus_if.pos, 0);
    repeat (3) idle();
    rst_n = 1'b1;
    check("reset_valid", bus_if.out_valid, 0);

    // Letter 1 at position 0, no step.
    cycle(1'b0, 0, 1'b1, 1, 1'b0);
    check("t1_pos", bus_if.pos, 0);
    idle();
    check("t1_letter", bus_if.out_letter, 6);
    check("t1_rotate", bus_if.out_rotate, 0);
    check("t1_step",   bus_if.step_out, 0);

    // Letter 1 with step from position 0.
    cycle(1'b1, 0, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1, 1'b1);
    check("t2_pos", bus_if.pos, 1);
    idle();
    check("t2_letter", bus_if.out_letter, 7);
    check("t2_rotate", bus_if.out_rotate, 1);

    // Position wrap 25 -> 0.
    cycle(1'b1, 25, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 7, 1'b1);
    check("wrap_pos", bus_if.pos, 0);
    idle();
    check("wrap_letter", bus_if.out_letter, 26);

    // Maximum sum 51.
    cycle(1'b1, 24, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 7, 1'b1);
    check("sum51_pos", bus_if.pos, 25);
    idle();
    check("sum51_letter", bus_if.out_letter, 25);

    // At the notch with no incoming step.
    cycle(1'b1, 4, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 1, 1'b0);
    check("notch_pos", bus_if.pos, NOTCH_POS_EXP);
    idle();
    check("notch_letter", bus_if.out_letter, NOTCH_LETTER_EXP);
    check("notch_step",   bus_if.step_out, NOTCH_STEP_EXP);

    // Back-to-back letters, each stepping.
    cycle(1'b1, 0, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 2, 1'b1);
    cycle(1'b0, 0, 1'b1, 2, 1'b1);
    check("b2b_letter0", bus_if.out_letter, 16);
    check("b2b_rotate0", bus_if.out_rotate, 1);
    cycle(1'b0, 0, 1'b1, 2, 1'b1);
    check("b2b_letter1", bus_if.out_letter, 17);
    check("b2b_rotate1", bus_if.out_rotate, 2);
    idle();
    check("b2b_letter2", bus_if.out_letter, 18);
    check("b2b_rotate2", bus_if.out_rotate, 3);

    // Invalid letter.
    cycle(1'b1, 3, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 0, 1'b1);
    check("badl_pos", bus_if.pos, 3);
    idle();
    check("badl_letter", bus_if.out_letter, 0);
    check("badl_err",    bus_if.err, 1);
    check("badl_valid",  bus_if.out_valid, 1);

    // Invalid load.
    cycle(1'b1, 30, 1'b1, 5, 1'b1);
    check("badld_pos", bus_if.pos, 0);
    check("badld_err", bus_if.err, 1);
    idle();

    // Reset with a letter in flight.
    cycle(1'b1, 10, 1'b0, 0, 1'b0);
    cycle(1'b0, 0, 1'b1, 9, 1'b1);
    #2;
    rst_n = 1'b0;
    for (int i = edge_cnt + 1; i < DEPTH; i++) begin
      exp_valid[i] = 1'b0; exp_letter[i] = 0; exp_rotate[i] = 0;
      exp_step[i] = 1'b0; exp_err[i] = 1'b0; exp_pos[i] = 0;
    end
    mpos = 0; hold_letter = 0; hold_rotate = 0;
    #1;
    check("rst_pos",   bus_if.pos, 0);
    check("rst_valid", bus_if.out_valid, 0);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst_no_valid", bus_if.out_valid, 0);
    end

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit ld, iv, si;
      int lp, il;
      ld = ($urandom_range(0, 99) < 6);
      lp = ($urandom_range(0, 3) == 0) ? NOTCH : $urandom_range(0, 31);
      iv = ($urandom_range(0, 99) < 80);
      il = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 31) : $urandom_range(1, 26);
      si = $urandom_range(0, 1);
      cycle(ld, lp, iv, il, si);
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rotor2_fwd.md
# rotor2_fwd

Forward-path (plug-board toward reflector) stage for Enigma rotor 2, the middle rotor.
- Holds the rotor position register and applies stepping, including the middle-rotor double-step.
- Substitutes each incoming letter through the rotor 2 wiring offset by the current position, over a 2-stage pipeline.
- Exports the position used for each letter, so the return path through the rotor 2 inverse undoes the same offset, plus the carry that steps rotor 3.

## Interface
Parameters:
- NOTCH, 5'd4: position at which rotor 2 turns over (E, 0-based).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  load rotor position from load_pos; has priority over in_valid.
- load_pos  in  5  new position, 0..25.
- in_valid  in  1  letter present this cycle; one letter per cycle, no backpressure.
- in_letter  in  5  letter 1..26 (A=1); 0 and 27..31 invalid.
- step_in  in  1  rotor 1 carry; qualified by in_valid.
- out_valid  out  1  one-cycle pulse, result valid.
- out_letter  out  5  substituted letter 1..26; 0 on error.
- out_rotate  out  5  position used for this letter; feeds the inverse stage.
- step_out  out  1  carry to rotor 3, aligned with out_valid.
- err  out  1  one-cycle pulse: invalid letter (aligned with out_valid) or invalid load (cycle after load).
- pos  out  5  live position register.

## Operation
Wiring table T, indexed by letter 1..26, gives:
- F O K U D A Z N Q P X W B J I E H C M S G L R Y T V
- Numerically: 6,15,11,21,4,1,26,14,17,16,24,23,2,10,9,5,8,3,13,19,7,12,18,25,20,22.

Load:
- load=1 and load_pos ≤ 25: pos ← load_pos.
- load=1 and load_pos > 25: pos ← 0 and err pulses the next cycle.
- in_valid in the same cycle is dropped; nothing enters the pipeline.

Accepted letter (in_valid=1, load=0):
- adv = step_in | (DS & pos==NOTCH), where DS is 1 only when the double-step feature is compiled in.
- pos_next = adv ? (pos==25 ? 0 : pos+1) : pos.
- carry = adv & (pos==NOTCH).
- Valid letter: pos ← pos_next (stepping precedes encipherment, as on the machine).
- Invalid letter: pos unchanged, carry forced 0, error flag carried down the pipeline.

Stage 1 register: t = T(in_letter), p = pos_next (pos if invalid), carry, error flag, valid.

Stage 2 register:
- sum = t + p, 6-bit, range 1..51.
- out_letter = sum > 26 ? sum − 26 : sum; result is always 1..26.
- out_rotate = p; step_out = carry.
- Error case: out_letter = 0, err = 1, step_out = 0.

Reset:
- rst_n low: pos, both stage registers and all outputs go to 0 immediately.
- Any in-flight letters are discarded.

## Timing
- Latency 2: letter accepted at edge N gives out_valid high in cycle N+2, for exactly one cycle.
- pos updates at edge N; the next letter accepted at N+1 sees the updated value.
- Full throughput: back-to-back letters each step independently.
- Load at edge N: pos is valid from N. Letters already in the pipeline keep their captured p.
- Outputs out_letter and out_rotate hold their last value between pulses; out_valid, step_out and err are 0 except during a pulse.

## Configuration
ROTOR2_DOUBLE_STEP_EN:
- Defined: rotor 2 also steps whenever it sits at NOTCH on an accepted letter (historical double-step); step_out fires on that letter.
- Undefined: pure odometer. Rotor 2 steps only on step_in, and step_out = step_in & pos==NOTCH.

## Test plan
- Reset, then letter 1 with step_in=0 → two cycles later out_letter 6, out_rotate 0, step_out 0; pos stays 0.
- pos=0, letter 1 with step_in=1 → pos 1, out_letter 7, out_rotate 1.
- Wrap cases:
  - load 25, then letter 7 with step_in=1 → pos 0, out_letter 26.
  - load 24, then letter 7 with step_in=1 → pos 25, sum 51, out_letter 25.
- load 4, then letter 1 with step_in=0:
  - Macro defined → pos 5, out_letter 11, step_out 1.
  - Macro undefined → pos 4, out_letter 10, step_out 0.
- Three consecutive letter 2 with step_in=1 from pos 0 → outputs 16, 17, 18 on consecutive cycles; out_rotate 1, 2, 3.
- Error and reset cases:
  - Letter 0 → out_letter 0 and err pulse, pos unchanged.
  - load_pos 30 → pos 0 and err pulse.
  - rst_n low while a letter is in flight → no out_valid ever appears for that letter.
